rle_encoder_p: RTL and testbench
================================

Name: rle_encoder_p

Overview:
- Parametrised run-length encoder coprocessor; next generation of the team's fixed 8-bit/32-bit RLE block.
- Reads a plaintext frame from a single-port SRAM, encodes it as packed {symbol, count} pairs, and writes the result back to the same SRAM.
- Generalised in symbol width, count width, memory word width and address width.
- Adds behaviour the previous generation lacks: run saturation/splitting, a busy flag, and zero-length frame handling.

Parameters:
- SYM_W, 8: symbol width in bits; multiple of 8.
- CNT_W, 8: run-count width in bits; multiple of 8. Maximum run is 2^CNT_W-1.
- DATA_W, 32: SRAM word width. Must be a multiple of both SYM_W and SYM_W+CNT_W.
- ADDR_W, 16: SRAM word-address width.

Ports:
- clk  in  1  system clock; also the SRAM clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- message_addr  in  ADDR_W  word address of the plaintext.
- message_size  in  32  plaintext length in bytes.
- rle_addr  in  ADDR_W  word address of the encoded output.
- mem_rdata  in  DATA_W  SRAM read data; 1-cycle read latency.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_addr  out  ADDR_W  SRAM word address.
- mem_we  out  1  SRAM write enable.
- busy  out  1  high from start acceptance until done.
- done  out  1  level; stays high until the next accepted start or reset.
- rle_size  out  32  encoded length in bytes; valid while done=1.

Behaviour:
- Reset values: state=IDLE; mem_we=0, mem_wdata=0, mem_addr=0, busy=0, done=0, rle_size=0. Reset mid-frame aborts immediately; no further writes occur.
- Derived constants:
  - NSYM = floor(message_size*8/SYM_W); trailing partial-symbol bytes are ignored.
  - SPW = DATA_W/SYM_W symbols per read word.
  - PPW = DATA_W/(SYM_W+CNT_W) pairs per write word.
- Pair layout: {symbol[SYM_W-1:0], count[CNT_W-1:0]}. Pair k of an output word occupies bits [(k+1)*PW-1 : k*PW], where PW = SYM_W+CNT_W (pair 0 is the LSBs). Within a read word, symbol 0 is the LSBs.
- FSM:
  - IDLE: on start, latch all inputs and clear counters; busy=1, done=0. Go to DONE if NSYM==0, else RD_REQ.
  - RD_REQ: mem_addr = message_addr + rd_word, mem_we=0. Next state RD_WAIT.
  - RD_WAIT: capture mem_rdata into the shift register; rd_word++. Next state SCAN.
  - SCAN: consume one symbol per cycle.
    - First symbol of the frame: cur_sym=sym, cur_cnt=1.
    - sym==cur_sym and cur_cnt < 2^CNT_W-1: cur_cnt++.
    - Otherwise (symbol differs, or count saturated): emit pair {cur_sym, cur_cnt}; reload cur_sym=sym, cur_cnt=1.
    - After the last symbol of the frame: emit the final pair, then go to FLUSH.
    - Else, after the last symbol of the word: go to RD_REQ.
  - Emit: append the pair to the pack buffer; pair_cnt++. When the buffer holds PPW pairs, go to WRITE immediately after the current symbol is processed, then return to the interrupted SCAN position or RD_REQ.
  - WRITE: mem_addr = rle_addr + wr_word, mem_we=1, mem_wdata = pack buffer; wr_word++; buffer cleared. Exactly one cycle.
  - FLUSH: if the buffer is non-empty, perform WRITE with the unused upper pairs zero-filled; then go to DONE.
  - DONE: busy=0, done=1, rle_size = pair_cnt*(SYM_W+CNT_W)/8.
- mem_we is high only in WRITE. A start pulse outside IDLE/DONE is ignored.
- Width rules: counters are 32 bits; word addresses wrap modulo 2^ADDR_W with no error flag.
- Throughput: 2 cycles per read word plus 1 cycle per symbol plus 1 cycle per write word.

Test Plan:
- Defaults, message_size=4, word 0x41414141 -> one write 0x00004104; rle_size=2; done=1.
- Defaults, size=8, words 0x44434241 and 0x44444444 -> writes 0x42014101, then 0x44054301; rle_size=8.
- Defaults, 300 bytes all 0x5A -> pairs {5A,FF} and {5A,2D}; single write 0x5A2D5AFF; rle_size=4.
- message_size=0 -> done within 2 cycles of start; rle_size=0; no mem_we pulses.
- Reset asserted mid-SCAN -> outputs return to reset values asynchronously; a new start then encodes correctly from scratch.
- SYM_W=16, CNT_W=16, DATA_W=64, size=8, halfwords 0x1111,0x1111,0x2222,0x2222 -> one write 0x2222_0002_1111_0002; rle_size=8.

Source files
------------

// File: rtl/rle_encoder_p.sv
// Run-length encoder coprocessor: reads a symbol frame from a single-port SRAM and
// writes packed {symbol, count} pairs back to it, splitting runs that saturate the count.
module rle_encoder_p #(
    parameter int SYM_W  = 8,
    parameter int CNT_W  = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_message_addr,
    input  logic [31:0]       i_message_size,
    input  logic [ADDR_W-1:0] i_rle_addr,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_rle_size
);

    localparam int PW         = SYM_W + CNT_W;
    localparam int SPW        = DATA_W / SYM_W;
    localparam int PPW        = DATA_W / PW;
    localparam int SYM_BYTES  = SYM_W / 8;
    localparam int PAIR_BYTES = PW / 8;
    localparam int SIDX_W     = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int PIDX_W     = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_SCAN, S_WRITE, S_FLUSH, S_DONE
    } state_t;

    state_t r_state, w_state_next;
    state_t r_ret, w_ret_next;

    logic [ADDR_W-1:0] r_maddr, r_raddr, r_rd_word, r_wr_word;
    logic [31:0]       r_nsym, r_sym_idx, r_pair_cnt;
    logic [SIDX_W-1:0] r_sidx;
    logic [PIDX_W-1:0] r_pidx;
    logic [DATA_W-1:0] r_shift;
    logic [SYM_W-1:0]  r_cur_sym;
    logic [CNT_W-1:0]  r_cur_cnt;
    logic [PW-1:0]     r_slot [PPW];

    logic [DATA_W-1:0] w_pack;
    logic [SYM_W-1:0]  w_sym;
    logic [PW-1:0]     w_pair;
    logic [31:0]       w_nsym_start;
    logic w_start_ok, w_first, w_extend, w_last_frame, w_last_word, w_append, w_buf_full;

    assign w_start_ok   = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_nsym_start = i_message_size / 32'(SYM_BYTES);
    assign w_sym        = r_shift[SYM_W-1:0];
    assign w_pair       = {r_cur_sym, r_cur_cnt};
    assign w_first      = (r_sym_idx == 32'd0);
    assign w_extend     = !w_first && (w_sym == r_cur_sym) && (r_cur_cnt != CNT_MAX);
    assign w_last_frame = (r_sym_idx == r_nsym - 32'd1);
    assign w_last_word  = (r_sidx == SIDX_W'(SPW - 1));
    // FLUSH appends the still-open run; SCAN appends the run a new symbol just closed.
    assign w_append     = (r_state == S_SCAN && !w_first && !w_extend) || (r_state == S_FLUSH);
    assign w_buf_full   = w_append && (r_pidx == PIDX_W'(PPW - 1));

    assign o_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done     = (r_state == S_DONE);
    assign o_rle_size = (r_state == S_DONE) ? r_pair_cnt * 32'(PAIR_BYTES) : 32'd0;

    // One register per pair slot; slot k sits at bits [(k+1)*PW-1 : k*PW] of the write word.
    generate
        for (genvar gi = 0; gi < PPW; gi++) begin : g_slot
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_slot[gi] <= '0;
                end else if (w_start_ok || r_state == S_WRITE) begin
                    r_slot[gi] <= '0;
                end else if (w_append && r_pidx == PIDX_W'(gi)) begin
                    r_slot[gi] <= w_pair;
                end
            end
            assign w_pack[gi*PW +: PW] = r_slot[gi];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_ret   <= S_IDLE;
        end else begin
            r_state <= w_state_next;
            r_ret   <= w_ret_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ret_next   = r_ret;
        o_mem_addr   = '0;
        o_mem_we     = 1'b0;
        o_mem_wdata  = '0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    w_state_next = (w_nsym_start == 32'd0) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                o_mem_addr   = r_maddr + r_rd_word;
                w_state_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_state_next = S_SCAN;
            end
            S_SCAN: begin
                if (w_last_frame) begin
                    w_state_next = S_FLUSH;
                end else if (w_last_word) begin
                    w_state_next = S_RD_REQ;
                end else begin
                    w_state_next = S_SCAN;
                end
                if (w_buf_full) begin
                    w_ret_next   = w_state_next;
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                o_mem_addr   = r_raddr + r_wr_word;
                o_mem_we     = 1'b1;
                o_mem_wdata  = w_pack;
                w_state_next = r_ret;
            end
            S_FLUSH: begin
                w_ret_next   = S_DONE;
                w_state_next = S_WRITE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_maddr    <= '0;
            r_raddr    <= '0;
            r_rd_word  <= '0;
            r_wr_word  <= '0;
            r_nsym     <= '0;
            r_sym_idx  <= '0;
            r_pair_cnt <= '0;
            r_sidx     <= '0;
            r_pidx     <= '0;
            r_shift    <= '0;
            r_cur_sym  <= '0;
            r_cur_cnt  <= '0;
        end else if (w_start_ok) begin
            r_maddr    <= i_message_addr;
            r_raddr    <= i_rle_addr;
            r_nsym     <= w_nsym_start;
            r_rd_word  <= '0;
            r_wr_word  <= '0;
            r_sym_idx  <= '0;
            r_pair_cnt <= '0;
            r_sidx     <= '0;
            r_pidx     <= '0;
            r_cur_sym  <= '0;
            r_cur_cnt  <= '0;
        end else begin
            case (r_state)
                S_RD_WAIT: begin
                    r_shift   <= i_mem_rdata;
                    r_rd_word <= r_rd_word + ADDR_W'(1);
                    r_sidx    <= '0;
                end
                S_SCAN: begin
                    r_shift   <= r_shift >> SYM_W;
                    r_sidx    <= r_sidx + SIDX_W'(1);
                    r_sym_idx <= r_sym_idx + 32'd1;
                    if (w_extend) begin
                        r_cur_cnt <= r_cur_cnt + CNT_W'(1);
                    end else begin
                        r_cur_sym <= w_sym;
                        r_cur_cnt <= CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    r_wr_word <= r_wr_word + ADDR_W'(1);
                    r_pidx    <= '0;
                end
                default: ;
            endcase
            if (w_append) begin
                r_pidx     <= r_pidx + PIDX_W'(1);
                r_pair_cnt <= r_pair_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_rle_encoder_p.sv
// Randomised bench for rle_encoder_p: two instances (8/8/32 and 16/16/64) against a
// run-list reference model, plus directed frames, zero-length and mid-frame reset.
module tb_rle_encoder_p;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    localparam logic [15:0] A_MSG = 16'd16;
    localparam logic [15:0] A_RLE = 16'd2048;
    localparam logic [11:0] B_MSG = 12'd32;
    localparam logic [11:0] B_RLE = 12'd1024;

    logic        a_start;
    logic [15:0] a_maddr, a_raddr, a_addr;
    logic [31:0] a_msize, a_rdata, a_wdata, a_rsize;
    logic        a_we, a_busy, a_done;

    logic        b_start;
    logic [11:0] b_maddr, b_raddr, b_addr;
    logic [31:0] b_msize, b_rsize;
    logic [63:0] b_rdata, b_wdata;
    logic        b_we, b_busy, b_done;

    rle_encoder_p dut_a (
        .i_clk(clk), .i_reset(rst), .i_start(a_start),
        .i_message_addr(a_maddr), .i_message_size(a_msize), .i_rle_addr(a_raddr),
        .i_mem_rdata(a_rdata), .o_mem_wdata(a_wdata), .o_mem_addr(a_addr),
        .o_mem_we(a_we), .o_busy(a_busy), .o_done(a_done), .o_rle_size(a_rsize)
    );

    rle_encoder_p #(.SYM_W(16), .CNT_W(16), .DATA_W(64), .ADDR_W(12)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_start(b_start),
        .i_message_addr(b_maddr), .i_message_size(b_msize), .i_rle_addr(b_raddr),
        .i_mem_rdata(b_rdata), .o_mem_wdata(b_wdata), .o_mem_addr(b_addr),
        .o_mem_we(b_we), .o_busy(b_busy), .o_done(b_done), .o_rle_size(b_rsize)
    );

    logic [31:0] mem_a [0:4095];
    logic [63:0] mem_b [0:4095];
    int unsigned wa_addr[$], wb_addr[$];
    logic [63:0] wa_data[$], wb_data[$];

    // SRAM models: 1-cycle read latency; writes are logged rather than stored.
    always @(posedge clk) begin
        a_rdata <= mem_a[a_addr[11:0]];
        b_rdata <= mem_b[b_addr];
        if (a_we) begin
            wa_addr.push_back(32'(a_addr));
            wa_data.push_back(64'(a_wdata));
        end
        if (b_we) begin
            wb_addr.push_back(32'(b_addr));
            wb_data.push_back(b_wdata);
        end
    end

    int total = 0;
    int bad   = 0;
    byte unsigned msg[$];
    longint unsigned exp_w[$];
    int exp_pairs;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: symbols -> maximal runs -> runs chopped at the count limit -> words of pairs.
    task automatic build_expect(input int symw, input int cntw, input int dataw);
        int nbw = symw / 8;
        int nsym = msg.size() / nbw;
        int pw = symw + cntw;
        int ppw = dataw / pw;
        longint unsigned maxc = (64'd1 << cntw) - 64'd1;
        longint unsigned syms[$], rsym[$], pairs[$];
        longint unsigned rlen[$];
        longint unsigned s, left, c, w;
        for (int i = 0; i < nsym; i++) begin
            s = 0;
            for (int b = 0; b < nbw; b++) s |= longint'(msg[i*nbw+b]) << (8*b);
            syms.push_back(s);
        end
        foreach (syms[i]) begin
            if (rsym.size() > 0 && rsym[rsym.size()-1] == syms[i]) rlen[rlen.size()-1]++;
            else begin
                rsym.push_back(syms[i]);
                rlen.push_back(1);
            end
        end
        foreach (rsym[r]) begin
            left = rlen[r];
            while (left > 0) begin
                c = (left > maxc) ? maxc : left;
                pairs.push_back((rsym[r] << cntw) | c);
                left -= c;
            end
        end
        exp_pairs = pairs.size();
        exp_w.delete();
        for (int i = 0; i < pairs.size(); i += ppw) begin
            w = 0;
            for (int k = 0; k < ppw && i + k < pairs.size(); k++) w |= pairs[i+k] << (k*pw);
            exp_w.push_back(w);
        end
    endtask

    task automatic gen_msg(input int n, input int mode);
        byte unsigned cur = 8'($urandom_range(0, 255));
        msg.delete();
        for (int i = 0; i < n; i++) begin
            if (mode == 0) msg.push_back(8'($urandom_range(0, 2) + 'h30));
            else if (mode == 1) begin
                if ($urandom_range(0, 99) < 2) cur = 8'($urandom_range(0, 255));
                msg.push_back(cur);
            end else msg.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    task automatic load_a();
        logic [31:0] w;
        for (int i = 0; i < (msg.size() + 3) / 4; i++) begin
            for (int b = 0; b < 4; b++)
                w[8*b +: 8] = (4*i + b < msg.size()) ? msg[4*i+b] : 8'($urandom_range(0, 255));
            mem_a[A_MSG[11:0] + 12'(i)] = w;
        end
    endtask

    task automatic load_b();
        logic [63:0] w;
        for (int i = 0; i < (msg.size() + 7) / 8; i++) begin
            for (int b = 0; b < 8; b++)
                w[8*b +: 8] = (8*i + b < msg.size()) ? msg[8*i+b] : 8'($urandom_range(0, 255));
            mem_b[B_MSG + 12'(i)] = w;
        end
    endtask

    task automatic kick_a();
        load_a();
        wa_addr.delete();
        wa_data.delete();
        @(negedge clk);
        a_msize = 32'(msg.size());
        a_maddr = A_MSG;
        a_raddr = A_RLE;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic run_a(input logic poke);
        int n = msg.size();
        int cyc = 0;
        kick_a();
        check_val("a_busy_after_start", 64'(a_busy), 64'(n > 0));
        check_val("a_done_after_start", 64'(a_done), 64'(n == 0));
        if (poke) begin
            repeat (3) @(negedge clk);
            a_msize = 32'd0;
            a_raddr = 16'd0;
            a_start = 1'b1;
            @(negedge clk);
            a_start = 1'b0;
        end
        while (!a_done && cyc < 4*n + 50) begin
            @(negedge clk);
            cyc++;
        end
        check_val("a_done", 64'(a_done), 64'd1);
        check_val("a_busy_end", 64'(a_busy), 64'd0);
        build_expect(8, 8, 32);
        check_val("a_nwrites", 64'(wa_data.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wa_data.size(); i++) begin
            check_val("a_wdata", wa_data[i], exp_w[i]);
            check_val("a_waddr", 64'(wa_addr[i]), 64'(A_RLE) + 64'(i));
        end
        check_val("a_rle_size", 64'(a_rsize), 64'(exp_pairs * 2));
        $display("A frame bytes=%0d pairs=%0d writes=%0d rle_size=%0d cycles=%0d",
                 n, exp_pairs, wa_data.size(), a_rsize, cyc);
    endtask

    task automatic run_b();
        int n = msg.size();
        int cyc = 0;
        load_b();
        wb_addr.delete();
        wb_data.delete();
        @(negedge clk);
        b_msize = 32'(n);
        b_maddr = B_MSG;
        b_raddr = B_RLE;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        check_val("b_busy_after_start", 64'(b_busy), 64'(n / 2 > 0));
        while (!b_done && cyc < 4*n + 50) begin
            @(negedge clk);
            cyc++;
        end
        check_val("b_done", 64'(b_done), 64'd1);
        build_expect(16, 16, 64);
        check_val("b_nwrites", 64'(wb_data.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wb_data.size(); i++) begin
            check_val("b_wdata", wb_data[i], exp_w[i]);
            check_val("b_waddr", 64'(wb_addr[i]), 64'(B_RLE) + 64'(i));
        end
        check_val("b_rle_size", 64'(b_rsize), 64'(exp_pairs * 4));
        $display("B frame bytes=%0d pairs=%0d writes=%0d rle_size=%0d cycles=%0d",
                 n, exp_pairs, wb_data.size(), b_rsize, cyc);
    endtask

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_maddr = '0; a_raddr = '0; a_msize = '0;
        b_start = 1'b0; b_maddr = '0; b_raddr = '0; b_msize = '0;
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_val("rst_we", 64'(a_we), 64'd0);
        check_val("rst_addr", 64'(a_addr), 64'd0);
        check_val("rst_wdata", 64'(a_wdata), 64'd0);
        check_val("rst_busy", 64'(a_busy), 64'd0);
        check_val("rst_done", 64'(a_done), 64'd0);
        check_val("rst_rle_size", 64'(a_rsize), 64'd0);
        check_val("rst_b_done", 64'(b_done), 64'd0);
        rst = 1'b0;

        // zero-length frame from IDLE
        msg.delete();
        run_a(1'b0);

        msg.delete();
        repeat (4) msg.push_back(8'h41);
        run_a(1'b0);
        check_val("tp1_word", (wa_data.size() > 0) ? wa_data[0] : '1, 64'h0000_4104);
        check_val("tp1_size", 64'(a_rsize), 64'd2);

        msg = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44};
        run_a(1'b0);
        check_val("tp2_word1", (wa_data.size() > 1) ? wa_data[1] : '1, 64'h4405_4301);

        msg.delete();
        repeat (300) msg.push_back(8'h5A);
        run_a(1'b0);
        check_val("tp3_word", (wa_data.size() > 0) ? wa_data[0] : '1, 64'h5A2D_5AFF);

        for (int t = 0; t < 12; t++) begin
            gen_msg($urandom_range(1, 600), t % 3);
            run_a(t % 4 == 0);
        end

        // reset in the middle of a scan
        gen_msg(200, 0);
        kick_a();
        repeat (20) @(negedge clk);
        check_val("mid_busy", 64'(a_busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_val("async_we", 64'(a_we), 64'd0);
        check_val("async_addr", 64'(a_addr), 64'd0);
        check_val("async_busy", 64'(a_busy), 64'd0);
        check_val("async_done", 64'(a_done), 64'd0);
        check_val("async_rle_size", 64'(a_rsize), 64'd0);
        repeat (3) @(negedge clk);
        wa_addr.delete();
        wa_data.delete();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_val("post_rst_nowrite", 64'(wa_data.size()), 64'd0);
        gen_msg(50, 0);
        run_a(1'b0);

        msg = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
        run_b();
        check_val("tp6_word", (wb_data.size() > 0) ? wb_data[0] : '1, 64'h2222_0002_1111_0002);
        check_val("tp6_size", 64'(b_rsize), 64'd8);
        for (int t = 0; t < 5; t++) begin
            gen_msg($urandom_range(1, 400), t % 3);
            run_b();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
